// File: rtl/wshb_sched_pkg.sv
// Shared types and constants for the three-requester Wishbone SDRAM scheduler.
package wshb_sched_pkg;
    localparam int NB_REQ = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = DATA_W / 8;

    typedef enum logic [1:0] {M_VGA, M_STREAM, M_MIRE, M_NONE} owner_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef struct packed {
        logic              cyc;
        logic              stb;
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] dat;
        logic [2:0]        cti;
        logic [1:0]        bte;
    } wb_req_t;

    function automatic logic [NB_REQ-1:0] owner_onehot(input owner_t o);
        case (o)
            M_VGA:    return 3'b001;
            M_STREAM: return 3'b010;
            M_MIRE:   return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction
endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle, master and slave views.
interface wshb_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_W-1:0]       adr;
    logic [DATA_BYTES-1:0]   sel;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (output cyc, stb, we, adr, sel, dat_ms, cti, bte,
                    input  dat_sm, ack, err, rty);
    modport slave  (input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
                    output dat_sm, ack, err, rty);
endinterface

// File: rtl/wshb_rr_pick.sv
// Combinational round-robin pick with a VGA urgency override.
module wshb_rr_pick
    import wshb_sched_pkg::*;
(
    input  logic [NB_REQ-1:0] req,
    input  owner_t            last,
    input  logic              urgent,
    output owner_t            pick
);
    always_comb begin
        pick = M_NONE;
        if (urgent && req[0]) begin
            pick = M_VGA;
        end else begin
            // Search starts just after the last owner; the last owner itself is tried last.
            case (last)
                M_VGA: begin
                    if (req[1])      pick = M_STREAM;
                    else if (req[2]) pick = M_MIRE;
                    else if (req[0]) pick = M_VGA;
                end
                M_STREAM: begin
                    if (req[2])      pick = M_MIRE;
                    else if (req[0]) pick = M_VGA;
                    else if (req[1]) pick = M_STREAM;
                end
                default: begin
                    if (req[0])      pick = M_VGA;
                    else if (req[1]) pick = M_STREAM;
                    else if (req[2]) pick = M_MIRE;
                end
            endcase
        end
    end
endmodule

// File: rtl/wshb_sched.sv
// Shares the SDRAM Wishbone slave between VGA reader, stream writer and mire,
// with round-robin, VGA urgency and a bounded burst length per grant.
module wshb_sched
    import wshb_sched_pkg::*;
#(
    parameter int MAX_BURST = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        vga_urgent,
    wshb_if.slave       wshb_ifs_vga,
    wshb_if.slave       wshb_ifs_stream,
    wshb_if.slave       wshb_ifs_mire,
    wshb_if.master      wshb_ifm,
    output logic [2:0]  grant
);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    owner_t            owner;
    owner_t            last;
    owner_t            pick;
    logic [BEAT_W-1:0] beats;
    wb_req_t           up [4];
    wb_req_t           fwd;
    logic [NB_REQ-1:0] req;
    logic [NB_REQ-1:0] own_oh;
    logic              others;
    logic              at_last;
    logic              term;

    assign up[M_VGA]    = {wshb_ifs_vga.cyc, wshb_ifs_vga.stb, wshb_ifs_vga.we, wshb_ifs_vga.adr,
                           wshb_ifs_vga.sel, wshb_ifs_vga.dat_ms, wshb_ifs_vga.cti, wshb_ifs_vga.bte};
    assign up[M_STREAM] = {wshb_ifs_stream.cyc, wshb_ifs_stream.stb, wshb_ifs_stream.we, wshb_ifs_stream.adr,
                           wshb_ifs_stream.sel, wshb_ifs_stream.dat_ms, wshb_ifs_stream.cti, wshb_ifs_stream.bte};
    assign up[M_MIRE]   = {wshb_ifs_mire.cyc, wshb_ifs_mire.stb, wshb_ifs_mire.we, wshb_ifs_mire.adr,
                           wshb_ifs_mire.sel, wshb_ifs_mire.dat_ms, wshb_ifs_mire.cti, wshb_ifs_mire.bte};
    assign up[M_NONE]   = '0;

    assign req     = {up[M_MIRE].cyc, up[M_STREAM].cyc, up[M_VGA].cyc};
    assign fwd     = up[owner];
    assign own_oh  = owner_onehot(owner);
    assign grant   = own_oh;
    assign others  = |(req & ~own_oh);
    assign at_last = (beats == LAST_BEAT);
    assign term    = fwd.cyc & fwd.stb & (wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty);

    wshb_rr_pick u_pick (
        .req    (req),
        .last   (last),
        .urgent (vga_urgent),
        .pick   (pick)
    );

    // Owner NONE forwards an all-zero request, so fwd.cyc low covers both idle and release.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            owner <= M_NONE;
            last  <= M_MIRE;
            beats <= '0;
        end else if (!fwd.cyc) begin
            owner <= pick;
            if (pick != M_NONE) last <= pick;
            beats <= '0;
        end else if (term) begin
            if (at_last) begin
                if (pick != owner) begin
                    owner <= pick;
                    last  <= pick;
                end
                beats <= '0;
            end else begin
                beats <= beats + 1'b1;
            end
        end
    end

    assign wshb_ifm.cyc    = fwd.cyc;
    assign wshb_ifm.stb    = fwd.stb;
    assign wshb_ifm.we     = fwd.we;
    assign wshb_ifm.adr    = fwd.adr;
    assign wshb_ifm.sel    = fwd.sel;
    assign wshb_ifm.dat_ms = fwd.dat;
    assign wshb_ifm.bte    = fwd.bte;
    // Close the burst cleanly on the last beat before a handover.
    assign wshb_ifm.cti    = (fwd.cyc && at_last && others) ? CTI_EOB : fwd.cti;

    assign wshb_ifs_vga.dat_sm    = wshb_ifm.dat_sm;
    assign wshb_ifs_stream.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs_mire.dat_sm   = wshb_ifm.dat_sm;
    assign wshb_ifs_vga.ack       = wshb_ifm.ack & own_oh[0];
    assign wshb_ifs_stream.ack    = wshb_ifm.ack & own_oh[1];
    assign wshb_ifs_mire.ack      = wshb_ifm.ack & own_oh[2];
    assign wshb_ifs_vga.err       = wshb_ifm.err & own_oh[0];
    assign wshb_ifs_stream.err    = wshb_ifm.err & own_oh[1];
    assign wshb_ifs_mire.err      = wshb_ifm.err & own_oh[2];
    assign wshb_ifs_vga.rty       = wshb_ifm.rty & own_oh[0];
    assign wshb_ifs_stream.rty    = wshb_ifm.rty & own_oh[1];
    assign wshb_ifs_mire.rty      = wshb_ifm.rty & own_oh[2];
endmodule

// File: tb/tb_wshb_sched.sv
// Scoreboard bench for wshb_sched: three behavioural masters, a zero-wait slave, MAX_BURST=4.
module tb_wshb_sched;
    import wshb_sched_pkg::*;

    localparam int MAXB = 4;

    typedef struct packed {
        logic [2:0]  grant;
        logic [2:0]  cti;
        logic        we;
        logic        err;
        logic [31:0] adr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        urgent = 1'b0;
    logic [2:0]  grant;
    logic [2:0]  up_ack;
    logic [2:0]  up_err;
    logic [31:0] err_adr = 32'hFFFF_FFFF;

    logic        m_cyc     [3];
    logic        m_classic [3];
    int          m_cnt     [3];
    int          m_beat    [3];

    int   compared = 0;
    int   mismatched = 0;
    int   cyc_cnt = 0;
    int   ack_n = 0;
    int   ack_first = 0;
    int   ack_last = 0;
    exp_t q[$];

    wshb_if up_if [3] ();
    wshb_if sd_if ();

    wshb_sched #(.MAX_BURST(MAXB)) dut (
        .sys_clk         (clk),
        .sys_rst         (rst),
        .vga_urgent      (urgent),
        .wshb_ifs_vga    (up_if[0]),
        .wshb_ifs_stream (up_if[1]),
        .wshb_ifs_mire   (up_if[2]),
        .wshb_ifm        (sd_if),
        .grant           (grant)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_adr(input int id, input int bt);
        return {4'(id + 1), 28'(bt * 4)};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_up
        assign up_if[g].cyc    = m_cyc[g];
        assign up_if[g].stb    = m_cyc[g];
        assign up_if[g].we     = (g == 1);
        assign up_if[g].adr    = mk_adr(g, m_beat[g]);
        assign up_if[g].sel    = 4'hF;
        assign up_if[g].dat_ms = ~mk_adr(g, m_beat[g]);
        assign up_if[g].cti    = m_classic[g] ? CTI_CLASSIC : ((m_cnt[g] == 1) ? CTI_EOB : CTI_INCR);
        assign up_if[g].bte    = 2'b00;
        assign up_ack[g]       = up_if[g].ack;
        assign up_err[g]       = up_if[g].err;
    end

    // Zero-wait slave; one programmable address answers with err instead of ack.
    assign sd_if.ack    = sd_if.cyc & sd_if.stb & (sd_if.adr != err_adr);
    assign sd_if.err    = sd_if.cyc & sd_if.stb & (sd_if.adr == err_adr);
    assign sd_if.rty    = 1'b0;
    assign sd_if.dat_sm = sd_if.adr ^ 32'hA5A5_A5A5;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int id, input int bt, input logic [2:0] cti, input logic err);
        exp_t e;
        e.grant = 3'(1 << id);
        e.cti   = cti;
        e.we    = (id == 1);
        e.err   = err;
        e.adr   = mk_adr(id, bt);
        q.push_back(e);
    endtask

    task automatic start(input int id, input int n, input logic classic);
        m_beat[id]    = 0;
        m_cnt[id]     = n;
        m_classic[id] = classic;
        m_cyc[id]     = 1'b1;
    endtask

    task automatic master_proc(input int id);
        forever begin
            @(negedge clk);
            if (m_cyc[id] && (up_ack[id] || up_err[id])) begin
                @(posedge clk);
                #1;
                if (m_cyc[id]) begin
                    m_beat[id]++;
                    m_cnt[id]--;
                    if (m_cnt[id] == 0) m_cyc[id] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !m_cyc[0] && !m_cyc[1] && !m_cyc[2]) break;
        end
        check({name, "_drain"}, {32'(q.size()), m_cyc[0], m_cyc[1], m_cyc[2]}, 0);
        q.delete();
        for (int i = 0; i < 3; i++) m_cyc[i] = 1'b0;
    endtask

    task automatic new_test();
        @(posedge clk);
        #1;
        ack_n = 0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Monitor: every downstream beat termination is matched against the next expected beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sd_if.cyc && sd_if.stb && (sd_if.ack || sd_if.err)) begin
                if (ack_n == 0) ack_first = cyc_cnt;
                ack_last = cyc_cnt;
                ack_n++;
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL beat_unexpected: actual grant=%b adr=%h, required no beat", grant, sd_if.adr);
                end else begin
                    e = q.pop_front();
                    check("beat", {grant, sd_if.cti, sd_if.we, sd_if.err, sd_if.adr, sd_if.dat_ms},
                          {e.grant, e.cti, e.we, e.err, e.adr, ~e.adr});
                    check("route", {up_ack, up_err}, e.err ? {3'b000, e.grant} : {e.grant, 3'b000});
                    check("dat_sm", {up_if[0].dat_sm, up_if[1].dat_sm, up_if[2].dat_sm},
                          {3{e.adr ^ 32'hA5A5_A5A5}});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [3];
        order = '{1, 2, 0};
        for (int i = 0; i < 3; i++) begin
            m_cyc[i] = 1'b0; m_classic[i] = 1'b0; m_cnt[i] = 0; m_beat[i] = 0;
        end
        fork
            master_proc(0);
            master_proc(1);
            master_proc(2);
        join_none

        // Reset: VGA requests but nothing may reach the slave.
        m_cyc[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_down", {sd_if.cyc, sd_if.stb, sd_if.we, sd_if.cti}, 0);
        check("reset_grant", grant, 0);
        check("reset_up", {up_ack, up_err}, 0);
        m_cyc[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // VGA alone, 10 classic reads.
        new_test();
        for (int b = 0; b < 10; b++) push(0, b, CTI_CLASSIC, 1'b0);
        start(0, 10, 1'b1);
        @(negedge clk);
        check("t1_no_stb_yet", {sd_if.stb, grant}, 0);
        @(negedge clk);
        check("t1_grant_latency", {sd_if.stb, grant}, {1'b1, 3'b001});
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!m_cyc[0]) break;
        end
        check("t1_release_cycle", {sd_if.cyc, grant}, {1'b0, 3'b001});
        @(negedge clk);
        check("t1_grant_none", grant, 0);
        wait_done("t1");
        check("t1_acks", ack_n, 10);

        // All three stream 8-beat bursts; last owner was VGA so STREAM leads.
        new_test();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++)
                for (int b = 0; b < 4; b++)
                    push(order[k], r * 4 + b, (b == 3) ? CTI_EOB : CTI_INCR, 1'b0);
        start(0, 8, 1'b0);
        start(1, 8, 1'b0);
        start(2, 8, 1'b0);
        wait_done("t2");
        check("t2_acks", ack_n, 24);
        check("t2_no_idle", ack_last - ack_first, 23);

        // Urgent VGA overrides round-robin at STREAM's preemption.
        new_test();
        for (int b = 0; b < 4; b++) push(1, b, (b == 3) ? CTI_EOB : CTI_INCR, 1'b0);
        for (int b = 0; b < 4; b++) push(0, b, (b == 3) ? CTI_EOB : CTI_INCR, 1'b0);
        for (int b = 4; b < 8; b++) push(1, b, (b == 7) ? CTI_EOB : CTI_INCR, 1'b0);
        for (int b = 0; b < 4; b++) push(2, b, (b == 3) ? CTI_EOB : CTI_INCR, 1'b0);
        start(1, 8, 1'b0);
        @(posedge clk);
        #1;
        check("t3_stream_owner", grant, 3'b010);
        urgent = 1'b1;
        start(0, 4, 1'b0);
        start(2, 4, 1'b0);
        wait_done("t3");
        urgent = 1'b0;

        // MIRE alone, 10 beats: kept across preemption points, no forced end-of-burst.
        new_test();
        for (int b = 0; b < 10; b++) push(2, b, (b == 9) ? CTI_EOB : CTI_INCR, 1'b0);
        start(2, 10, 1'b0);
        wait_done("t4");
        check("t4_acks", ack_n, 10);
        check("t4_no_idle", ack_last - ack_first, 9);

        // Reset in the middle of a STREAM burst.
        new_test();
        push(1, 0, CTI_INCR, 1'b0);
        push(1, 1, CTI_INCR, 1'b0);
        start(1, 8, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (m_beat[1] >= 2) break;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_cyc[i] = 1'b0;
            m_cnt[i] = 0;
        end
        #1;
        check("t5_async_down", {sd_if.cyc, sd_if.stb, grant}, 0);
        check("t5_beats_before_rst", 32'(q.size()), 0);
        @(negedge clk);
        rst = 1'b0;
        new_test();
        push(0, 0, CTI_EOB, 1'b0);
        push(1, 0, CTI_EOB, 1'b0);
        start(0, 1, 1'b0);
        start(1, 1, 1'b0);
        @(posedge clk);
        #1;
        check("t5_vga_first", grant, 3'b001);
        wait_done("t5");

        // err on VGA's second beat counts toward the burst limit and reaches VGA only.
        new_test();
        err_adr = mk_adr(0, 1);
        push(0, 0, CTI_INCR, 1'b0);
        push(0, 1, CTI_INCR, 1'b1);
        push(0, 2, CTI_INCR, 1'b0);
        push(0, 3, CTI_EOB,  1'b0);
        push(1, 0, CTI_EOB,  1'b0);
        push(0, 4, CTI_INCR, 1'b0);
        push(0, 5, CTI_EOB,  1'b0);
        start(0, 6, 1'b0);
        start(1, 1, 1'b0);
        wait_done("t6");
        err_adr = 32'hFFFF_FFFF;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/wshb_sched.md
# wshb_sched

Three-requester Wishbone scheduler sharing the single SDRAM slave port (`wshb_if_sdram` of `hw_support`) between the VGA frame reader, the incoming video stream writer and the mire generator. Round-robin arbitration, a VGA urgency override driven by the VGA FIFO level, and a bounded burst length so that no master can starve the display. Sits in `Top` on `sys_clk`, between the three master-side interfaces and `hw_support`.

## Interface
- `MAX_BURST`, 64: maximum acked beats per grant before forced re-arbitration (≥2).
- `sys_clk`  in  1  system clock, 100 MHz; all logic on its rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `vga_urgent`  in  1  VGA FIFO below low-water mark, `sys_clk` domain.
- `wshb_ifs_vga`  wshb_if.slave  DATA_BYTES=4  requester 0 (VGA reader).
- `wshb_ifs_stream`  wshb_if.slave  DATA_BYTES=4  requester 1 (stream writer).
- `wshb_ifs_mire`  wshb_if.slave  DATA_BYTES=4  requester 2 (mire).
- `wshb_ifm`  wshb_if.master  DATA_BYTES=4  to SDRAM controller.
- `grant`  out  3  one-hot current owner, bit 0 = VGA; debug/LED use.

## Operation
- Request = requester `cyc`. State is `owner` ∈ {NONE, VGA, STREAM, MIRE}, `last` (last owner, for round-robin), `beats` (acked-beat counter, width $clog2(MAX_BURST+1)).
- Pick rule, evaluated on any edge where re-arbitration is due:
  - If `vga_urgent` and VGA requests, pick VGA.
  - Otherwise, pick the first requesting master after `last` in cyclic order VGA→STREAM→MIRE.
  - If nobody requests, pick NONE.
- Re-arbitration is due when:
  - `owner`=NONE, or
  - the owner's `cyc` is low, or
  - `beats`=MAX_BURST (preemption).
- Preemption only hands over if another master requests. Otherwise `beats` clears and the owner keeps the grant.
- On each grant change, `last`←new owner and `beats`←0. `beats` increments on each downstream `ack`.
- Forwarding while owner≠NONE is combinational from the owner:
  - `cyc`, `stb`, `we`, `adr`, `sel`, `dat_ms` and `bte` are forwarded as-is.
  - `cti` is forwarded, except it is forced to 3'b111 on the beat where `beats`=MAX_BURST-1 and another master requests. The slave therefore sees a clean end-of-burst.
- While owner=NONE, all downstream controls are 0.
- Return path:
  - `dat_sm` is broadcast to all three requesters.
  - `ack`, `err` and `rty` are routed to the owner only; non-owners see 0.
  - A preempted master keeps `cyc` high and simply sees wait states until it is granted again.
- `err` and `rty` count as beat terminations for `beats`.

## Timing
- Reset values: `owner`=NONE, `last`=MIRE (so VGA wins first round-robin), `beats`=0, `grant`=3'b000, downstream `cyc`/`stb`/`we`=0, upstream `ack`/`err`/`rty`=0.
- Grant latency: a request sampled at edge N while idle gives the grant and downstream `stb` in cycle N+1.
- Handover: if the owner drops `cyc` in cycle N, the new owner is forwarded in cycle N+1. Exactly one idle downstream cycle, never zero.
- Preemption: the MAX_BURST-th `ack` at edge N means the new owner drives in cycle N+1.
- Simultaneous events:
  - A `vga_urgent` rising edge during another owner's burst does not abort the burst. It only affects the next pick.
  - If the owner drops `cyc` on the same edge as the MAX_BURST-th ack, this is treated as a normal release.
- `sys_rst` mid-burst: downstream `cyc`/`stb` fall asynchronously and the pending beat is lost. Requesters must restart after reset.
- `beats` never exceeds MAX_BURST and never wraps.

## Structure
- `wshb_sched_pkg` holds:
  - `typedef enum logic [1:0] {M_VGA, M_STREAM, M_MIRE, M_NONE} owner_t`;
  - CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111);
  - `NB_REQ = 3`.
- Sub-module `wshb_rr_pick`: combinational pick from request vector, `last` and `urgent`. Shared later with any other round-robin arbiter.
- `wshb_sched` contains the owner/`beats` registers and the forwarding muxes. It replaces `wshb_intercon` in `Top`.

## Test plan
- Reset, then VGA alone issues 10 classic reads: first `stb` one cycle after `cyc`, 10 acks routed only to VGA, `grant`=001, then NONE one cycle after `cyc` falls.
- VGA, STREAM and MIRE all request continuous bursts with MAX_BURST=4: grants rotate VGA→STREAM→MIRE→VGA with 4 acks each. Downstream `cti`=3'b111 on every 4th beat. No idle cycle at preemption.
- STREAM owns the bus while VGA and MIRE request and `vga_urgent`=1: after STREAM's 4th ack VGA is granted, not MIRE, even though round-robin order says MIRE.
- MIRE alone with 10-beat burst and MAX_BURST=4: grant never changes, `beats` clears at 4 and 8, no forced `cti`=3'b111.
- `sys_rst` pulsed mid-burst of STREAM: downstream `cyc`/`stb` go 0 within the reset cycle, `grant`=000, and after release VGA is first granted.
- Slave returns `err` on beat 2 of VGA: `err` seen only by VGA, `beats`=2, STREAM/MIRE `ack`/`err` stay 0.
